// File: rtl/brs_pkg.sv
// Shared types and constants for the BRS UART transmitter.
// Optional macro BRS_UART_PARITY_EN adds an even-parity bit to every frame.
package brs_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int UART_DATA_BITS = 8;

`ifdef BRS_UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

endpackage

// File: rtl/brs_byte_fifo.sv
// Small synchronous byte FIFO with registered full/empty flags and count.
// DEPTH must be a power of two so the pointers wrap naturally.
module brs_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_n;
    logic          do_push;
    logic          do_pop;

    // Guard the strobes so a full or empty FIFO can never be corrupted.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Next occupancy: a simultaneous push and pop cancel out.
    always_comb begin
        count_n = count;
        if (do_push && !do_pop) begin
            count_n = count + 1'b1;
        end else if (!do_push && do_pop) begin
            count_n = count - 1'b1;
        end
    end

    // Pointer, count and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_n;
            full  <= (count_n == FULL_CNT);
            empty <= (count_n == '0);
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/brs_uart_tx.sv
// UART transmitter: buffers bytes from the BRS core and sends them as
// 8N1 frames, LSB first. Optional macro BRS_UART_PARITY_EN inserts an
// even-parity bit between the data bits and the stop bit.
module brs_uart_tx
    import brs_pkg::*;
#(
    parameter int CLK_DIV    = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [2:0]  LAST_BIT = 3'(UART_DATA_BITS - 1);

    tx_state_t  state, state_n;
    logic [15:0] div, div_n;
    logic [2:0]  bit_cnt, bit_n;
    logic [7:0]  shift, shift_n;
    logic        tx_n;
    logic        busy_n;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic [7:0]  head;
    logic [$clog2(FIFO_DEPTH):0] count;
    logic        div_last;
`ifdef BRS_UART_PARITY_EN
    logic        par, par_n;
`endif

    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign div_last = (div == DIV_LAST);

    brs_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // Frame sequencing: next state, divider, shifter and line level.
    always_comb begin
        state_n    = state;
        div_n      = div;
        bit_n      = bit_cnt;
        shift_n    = shift;
        tx_n       = tx;
        pop        = 1'b0;
        frame_done = 1'b0;
`ifdef BRS_UART_PARITY_EN
        par_n      = par;
`endif
        unique case (state)
            IDLE: begin
                div_n = '0;
                bit_n = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = head;
                    tx_n    = 1'b0;
                    state_n = START;
`ifdef BRS_UART_PARITY_EN
                    par_n   = ^head;
`endif
                end
            end
            START: begin
                if (div_last) begin
                    div_n   = '0;
                    tx_n    = shift[0];
                    state_n = DATA;
                end else begin
                    div_n = div + 16'd1;
                end
            end
            DATA: begin
                if (div_last) begin
                    div_n = '0;
                    if (bit_cnt == LAST_BIT) begin
`ifdef BRS_UART_PARITY_EN
                        tx_n    = par;
                        state_n = PARITY;
`else
                        tx_n    = 1'b1;
                        state_n = STOP;
`endif
                    end else begin
                        bit_n   = bit_cnt + 3'd1;
                        shift_n = {1'b0, shift[7:1]};
                        tx_n    = shift[1];
                    end
                end else begin
                    div_n = div + 16'd1;
                end
            end
`ifdef BRS_UART_PARITY_EN
            PARITY: begin
                if (div_last) begin
                    div_n   = '0;
                    tx_n    = 1'b1;
                    state_n = STOP;
                end else begin
                    div_n = div + 16'd1;
                end
            end
`endif
            STOP: begin
                if (div_last) begin
                    div_n      = '0;
                    frame_done = 1'b1;
                    tx_n       = 1'b1;
                    state_n    = IDLE;
                end else begin
                    div_n = div + 16'd1;
                end
            end
            default: begin
                div_n   = '0;
                tx_n    = 1'b1;
                state_n = IDLE;
            end
        endcase
        // A pop always leaves IDLE, so only the push needs separate cover.
        busy_n = (state_n != IDLE) || (count != '0) || push;
    end

    // Control registers; reset returns the line to idle mid-frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            div     <= '0;
            bit_cnt <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            div     <= div_n;
            bit_cnt <= bit_n;
            tx      <= tx_n;
            busy    <= busy_n;
        end
    end

    // Data registers; always loaded before use so no reset is needed.
    always_ff @(posedge clk) begin
        shift <= shift_n;
`ifdef BRS_UART_PARITY_EN
        par   <= par_n;
`endif
    end

endmodule

// File: tb/tb_brs_uart_tx.sv
// Directed self-checking bench for brs_uart_tx (CLK_DIV=4, FIFO_DEPTH=4).
// Honours BRS_UART_PARITY_EN when it is defined for the build.
module tb_brs_uart_tx;
    import brs_pkg::*;

    localparam int D  = 4;
    localparam int NB = FRAME_BITS;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic       frame_done;

    int n_chk  = 0;
    int n_pass = 0;

    brs_uart_tx #(.CLK_DIV(D), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [15:0] exp_frame(input logic [7:0] d);
`ifdef BRS_UART_PARITY_EN
        return {5'b0, 1'b1, ^d, d, 1'b0};
`else
        return {6'b0, 1'b1, d, 1'b0};
`endif
    endfunction

    // Present a byte and hold it until accepted; returns at the negedge after the accepting edge.
    task automatic push_byte(input logic [7:0] b, output int waited);
        in_valid = 1'b1;
        in_data  = b;
        waited   = 0;
        while (in_ready !== 1'b1 && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Advance negedge by negedge until tx is low; n counts high cycles seen.
    task automatic wait_low(input int budget, output bit ok, output int n,
                            output logic prev, output int fdc);
        ok   = 1'b0;
        n    = 0;
        fdc  = 0;
        prev = in_ready;
        while (n < budget) begin
            @(negedge clk);
            if (frame_done === 1'b1) fdc++;
            if (tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
            prev = in_ready;
            n++;
        end
    endtask

    // Record a frame; the current negedge is its first (start-bit) cycle.
    task automatic recv_frame(output logic [15:0] bits, output bit stable,
                              output int fd_cnt, output int fd_pos);
        int j;
        bits   = '0;
        stable = 1'b1;
        fd_cnt = 0;
        fd_pos = 0;
        for (int c = 1; c <= NB * D; c++) begin
            if (c > 1) @(negedge clk);
            j = (c - 1) / D;
            if ((c - 1) % D == 0) bits[j] = tx;
            else if (tx !== bits[j]) stable = 1'b0;
            if (frame_done === 1'b1) begin
                fd_cnt++;
                fd_pos = c;
            end
        end
    endtask

    logic [7:0]  sb [20];
    logic [15:0] bits;
    bit          st;
    bit          ok;
    int          fc, fp, n, w, fdc;
    logic        pr, r1;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Reset held three cycles, then released.
        repeat (3) begin
            @(negedge clk);
            chk("rst_tx", tx, 1);
            chk("rst_ready", in_ready, 1);
            chk("rst_busy", busy, 0);
            chk("rst_fdone", frame_done, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_tx", tx, 1);
        chk("post_rst_ready", in_ready, 1);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_fdone", frame_done, 0);

        // Single byte 0xA5: latency, bit pattern, frame_done position.
        in_data  = 8'hA5;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("lat_tx_high", tx, 1);
        chk("lat_busy", busy, 1);
        @(negedge clk);
        chk("lat_tx_low", tx, 0);
        recv_frame(bits, st, fc, fp);
`ifdef BRS_UART_PARITY_EN
        chk("a5_frame", bits, 16'h054A);
        chk("a5_parity", bits[9], 0);
`else
        chk("a5_frame", bits, 16'h034A);
`endif
        chk("a5_stable", st, 1);
        chk("a5_fd_cnt", fc, 1);
        chk("a5_fd_pos", fp, NB * D);
        @(negedge clk);
        chk("a5_idle_busy", busy, 0);
        chk("a5_idle_tx", tx, 1);

        // Fill: 0x01..0x05 back-to-back, frames in order with D+1 idle cycles between.
        fork
            begin
                for (int i = 1; i <= 5; i++) begin
                    push_byte(8'(i), w);
                    chk("fill_nowait", w, 0);
                end
                chk("fill_ready_low", in_ready, 0);
            end
            begin
                wait_low(200, ok, n, pr, fdc);
                chk("fill_start", ok, 1);
                for (int f = 0; f < 5; f++) begin
                    recv_frame(bits, st, fc, fp);
                    chk("fill_frame", bits, exp_frame(8'(f + 1)));
                    chk("fill_stable", st, 1);
                    chk("fill_fd_pos", fp, NB * D);
                    if (f < 4) begin
                        wait_low(4 * D, ok, n, pr, fdc);
                        chk("fill_next_start", ok, 1);
                        chk("fill_gap", D + n, D + 1);
                    end
                end
            end
        join
        @(negedge clk);
        chk("fill_done_busy", busy, 0);

        // Scoreboard: 20 random bytes with in_valid held continuously.
        for (int i = 0; i < 20; i++) sb[i] = 8'($urandom_range(255));
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    push_byte(sb[i], w);
                    chk("sb_push_timeout", (w < 1000), 1);
                end
            end
            begin
                wait_low(200, ok, n, pr, fdc);
                chk("sb_start", ok, 1);
                for (int f = 0; f < 20; f++) begin
                    r1 = in_ready;
                    if (f >= 1 && f <= 15) begin
                        chk("sb_ready_before_pop", pr, 0);
                        chk("sb_ready_after_pop", r1, 1);
                    end
                    recv_frame(bits, st, fc, fp);
                    chk("sb_data", bits[8:1], sb[f]);
                    chk("sb_frame", bits, exp_frame(sb[f]));
                    chk("sb_fd_cnt", fc, 1);
                    if (f < 19) begin
                        wait_low(4 * D, ok, n, pr, fdc);
                        chk("sb_next_start", ok, 1);
                        chk("sb_gap", D + n, D + 1);
                    end
                end
            end
        join
        wait_low(100, ok, n, pr, fdc);
        chk("sb_no_extra_frame", ok, 0);
        chk("sb_end_busy", busy, 0);

        // Reset during data bit 3 of 0x3C with a second byte still queued.
        push_byte(8'h3C, w);
        push_byte(8'h55, w);
        chk("mr_started", tx, 0);
        repeat (17) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mr_tx", tx, 1);
        chk("mr_ready", in_ready, 1);
        chk("mr_busy", busy, 0);
        chk("mr_fdone", frame_done, 0);
        rst = 1'b0;
        wait_low(60, ok, n, pr, fdc);
        chk("mr_flushed", ok, 0);
        chk("mr_no_fdone", fdc, 0);
        chk("mr_idle_busy", busy, 0);
        push_byte(8'h3C, w);
        wait_low(10, ok, n, pr, fdc);
        chk("mr_restart", ok, 1);
        recv_frame(bits, st, fc, fp);
`ifdef BRS_UART_PARITY_EN
        chk("mr_frame", bits, 16'h0478);
`else
        chk("mr_frame", bits, 16'h0278);
`endif
        chk("mr_stable", st, 1);
        chk("mr_fd_pos", fp, NB * D);

`ifdef BRS_UART_PARITY_EN
        // Odd-weight byte gives parity bit 1.
        @(negedge clk);
        push_byte(8'h07, w);
        wait_low(10, ok, n, pr, fdc);
        chk("p07_start", ok, 1);
        recv_frame(bits, st, fc, fp);
        chk("p07_parity", bits[9], 1);
        chk("p07_frame", bits, 16'h060E);
        chk("p07_fd_pos", fp, 44);
`endif

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
